switch_debouncer: RTL and testbench

Upstream input stage of the DIP-switch game. It takes the raw, asynchronous 8-bit DIP-switch bus, synchronises it to `clk`, and filters it as a whole word. It publishes a debounced value plus a one-cycle change strobe that the game state machine uses in place of the raw pins. The game's PREGAME start check and GUESSING compare both read `value`, so a bouncing switch can never produce a spurious match.

---
 rtl/switch_debouncer_pkg.sv | 13 +
 rtl/switch_debouncer_bit_synchronizer.sv | 23 ++
 rtl/switch_debouncer.sv | 92 +++++++++
 tb/tb_switch_debouncer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared constants for the DIP-switch debouncer: FSM encoding, default sizes
// and the glitch counter saturation limit.
package switch_debouncer_pkg;

    localparam logic STABLE   = 1'b0;
    localparam logic SETTLING = 1'b1;

    localparam int DEFAULT_WIDTH           = 8;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    localparam logic [7:0] GLITCH_MAX = 8'd255;

endpackage

// File: rtl/switch_debouncer_bit_synchronizer.sv
// Parameterised-width 2-flop synchroniser with asynchronous active-high reset to 0.
module bit_synchronizer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Whole-word debouncer for the raw DIP-switch bus: synchronise, qualify, commit.
// Optional glitch counter enabled by defining SWITCH_DEBOUNCE_GLITCH_CNT_EN.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] value,
    output logic             changed,
    output logic             settling,
    output logic [7:0]       glitch_count
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;
    logic             state;

    bit_synchronizer #(.WIDTH(WIDTH)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw_raw),
        .q   (sync_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= STABLE;
            cand    <= '0;
            cnt     <= '0;
            value   <= '0;
            changed <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (state == STABLE) begin
                if (sync_q != value) begin
                    cand  <= sync_q;
                    cnt   <= '0;
                    state <= SETTLING;
                end
            end else begin
                // Any deviation from the candidate aborts or restarts the word.
                if (sync_q != cand) begin
                    if (sync_q == value) begin
                        state <= STABLE;
                    end else begin
                        cand <= sync_q;
                        cnt  <= '0;
                    end
                end else if (cnt == CNT_LAST) begin
                    value   <= cand;
                    changed <= 1'b1;
                    state   <= STABLE;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign settling = (state == SETTLING);

`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == GLITCH_MAX) ? c : c + 8'd1;
    endfunction

    // Both the bounce-back and the restart branch fire exactly when the
    // synchronised word departs from the candidate during qualification.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_q <= 8'd0;
        end else if (state == SETTLING && sync_q != cand) begin
            glitch_q <= sat_inc(glitch_q);
        end
    end

    assign glitch_count = glitch_q;
`else
    assign glitch_count = 8'd0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed, table-driven bench for switch_debouncer with DEBOUNCE_CYCLES = 4.
module tb_switch_debouncer;

    localparam int DC = 4;
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
    localparam int GLITCH_ON = 1;
`else
    localparam int GLITCH_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw_raw;
    logic [7:0] value;
    logic       changed;
    logic       settling;
    logic [7:0] glitch_count;

    int checks = 0;
    int errors = 0;

    switch_debouncer #(.WIDTH(8), .DEBOUNCE_CYCLES(DC)) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_raw       (sw_raw),
        .value        (value),
        .changed      (changed),
        .settling     (settling),
        .glitch_count (glitch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sw;
        logic [7:0] value;
        logic       changed;
        logic       settling;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One active edge, then sample 1 ns later; inputs are driven at this point too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        sw_raw = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
    endtask

    function automatic logic [7:0] exp_glitch(input int n);
        return (GLITCH_ON != 0) ? 8'(n) : 8'd0;
    endfunction

    initial begin
        tbl[0]  = '{8'h5A, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{8'h5A, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{8'h5A, 8'h00, 1'b0, 1'b1};
        tbl[3]  = '{8'h5A, 8'h00, 1'b0, 1'b1};
        tbl[4]  = '{8'h5A, 8'h00, 1'b0, 1'b1};
        tbl[5]  = '{8'h5A, 8'h00, 1'b0, 1'b1};
        tbl[6]  = '{8'h5A, 8'h5A, 1'b1, 1'b0};
        tbl[7]  = '{8'h5A, 8'h5A, 1'b0, 1'b0};
        tbl[8]  = '{8'h00, 8'h5A, 1'b0, 1'b0};
        tbl[9]  = '{8'h00, 8'h5A, 1'b0, 1'b0};
        tbl[10] = '{8'h00, 8'h5A, 1'b0, 1'b1};
        tbl[11] = '{8'h00, 8'h5A, 1'b0, 1'b1};
        tbl[12] = '{8'h00, 8'h5A, 1'b0, 1'b1};
        tbl[13] = '{8'h00, 8'h5A, 1'b0, 1'b1};
        tbl[14] = '{8'h00, 8'h00, 1'b1, 1'b0};
        tbl[15] = '{8'h00, 8'h00, 1'b0, 1'b0};

        // Reset held with all switches on, then release.
        rst    = 1'b1;
        sw_raw = 8'hFF;
        tick();
        tick();
        chk("rst_value", 32'(value), 32'h00);
        chk("rst_changed", 32'(changed), 32'h0);
        chk("rst_settling", 32'(settling), 32'h0);
        chk("rst_glitch", 32'(glitch_count), 32'h0);
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("rel_value_e%0d", k), 32'(value), (k >= 7) ? 32'hFF : 32'h00);
            chk($sformatf("rel_changed_e%0d", k), 32'(changed), (k == 7) ? 32'h1 : 32'h0);
        end

        // Clean changes 00 -> 5A -> 00.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            sw_raw = tbl[i].sw;
            tick();
            chk($sformatf("tbl%0d_value", i), 32'(value), 32'(tbl[i].value));
            chk($sformatf("tbl%0d_changed", i), 32'(changed), 32'(tbl[i].changed));
            chk($sformatf("tbl%0d_settling", i), 32'(settling), 32'(tbl[i].settling));
        end
        chk("clean_glitch", 32'(glitch_count), 32'h0);

        // Bounce back to the old word.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            sw_raw = (k < 2) ? 8'h01 : 8'h00;
            tick();
            chk($sformatf("bounce_value_e%0d", k), 32'(value), 32'h00);
            chk($sformatf("bounce_changed_e%0d", k), 32'(changed), 32'h0);
            chk($sformatf("bounce_settling_e%0d", k), 32'(settling),
                (k == 2 || k == 3) ? 32'h1 : 32'h0);
        end
        chk("bounce_glitch", 32'(glitch_count), 32'(exp_glitch(1)));

        // Restart on a different candidate: 01 is never committed.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            sw_raw = (k < 2) ? 8'h01 : 8'h03;
            tick();
            chk($sformatf("restart_value_e%0d", k), 32'(value), (k >= 8) ? 32'h03 : 32'h00);
            chk($sformatf("restart_changed_e%0d", k), 32'(changed), (k == 8) ? 32'h1 : 32'h0);
        end
        chk("restart_glitch", 32'(glitch_count), 32'(exp_glitch(1)));

        // 300 aborted bounces saturate the counter.
        do_reset();
        for (int b = 0; b < 300; b++) begin
            for (int k = 0; k < 5; k++) begin
                sw_raw = (k < 2) ? 8'h01 : 8'h00;
                tick();
            end
        end
        chk("sat_glitch", 32'(glitch_count), 32'(exp_glitch(255)));
        chk("sat_value", 32'(value), 32'h00);

        // Reset in the middle of a qualification.
        do_reset();
        sw_raw = 8'h5A;
        for (int k = 0; k < 8; k++) tick();
        chk("mid_pre_value", 32'(value), 32'h5A);
        sw_raw = 8'hA5;
        for (int k = 0; k < 4; k++) tick();
        chk("mid_pre_settling", 32'(settling), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_value", 32'(value), 32'h00);
        chk("mid_rst_settling", 32'(settling), 32'h0);
        chk("mid_rst_changed", 32'(changed), 32'h0);
        chk("mid_rst_glitch", 32'(glitch_count), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mid_hold_changed_%0d", k), 32'(changed), 32'h0);
        end
        sw_raw = 8'h00;
        rst    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("mid_post_changed_%0d", k), 32'(changed), 32'h0);
            chk($sformatf("mid_post_value_%0d", k), 32'(value), 32'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
